// File: rtl/csr_counter_bank.sv
// +--------------------------------------------------------------------------+
// | csr_counter_bank: 64-bit cycle/time/instret/hpm counters with CSR access |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module csr_counter_bank #(
  parameter int NUM_HPM = 4,
  parameter bit TIME_EN = 1'b1,
  localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic [11:0]      read_address,
  output logic [31:0]      read_data,
  output logic             read_valid,
  output logic             read_error,
  input  logic [1:0]       write_back,
  input  logic [11:0]      write_back_address,
  input  logic [31:0]      write_back_data,
  output logic             write_error,
  input  logic             increment_instret,
  input  logic             time_tick,
  input  logic [HPM_W-1:0] hpm_event
);

  localparam logic [63:0] HPM_BITS     = ((64'd1 << NUM_HPM) - 64'd1) << 3;
  localparam logic [31:0] INHIBIT_MASK = 32'h0000_0005 | HPM_BITS[31:0];

  logic [63:0] cycle_q;
  logic [63:0] time_q;
  logic [63:0] instret_q;
  logic [63:0] hpm_q [HPM_W];
  logic [31:0] inhibit_q;

  logic [31:0] rd_value;
  logic        rd_hit;
  logic [31:0] wb_old;
  logic        wb_hit;
  logic        wb_req;
  logic        wb_ok;
  logic        wb_do;
  logic [31:0] wb_new;

  // Both the read and write-back ports decode through the same address map.
  function automatic void lookup(input logic [11:0] a, output logic [31:0] v,
                                 output logic hit);
    logic [63:0] sel;
    logic        ro;
    logic [6:0]  idx;
    v   = '0;
    hit = 1'b0;
    sel = '0;
    ro  = (a[11:8] == 4'hC);
    idx = a[6:0];
    if (a == 12'h320) begin
      v   = inhibit_q;
      hit = 1'b1;
    end else if (a[11:8] == 4'hC || a[11:8] == 4'hB) begin
      if (idx == 7'd0) begin
        sel = cycle_q;
        hit = 1'b1;
      end else if (idx == 7'd1 && ro && TIME_EN) begin
        sel = time_q;
        hit = 1'b1;
      end else if (idx == 7'd2) begin
        sel = instret_q;
        hit = 1'b1;
      end else begin
        for (int i = 0; i < NUM_HPM; i++) begin
          if (idx == 7'(i + 3)) begin
            sel = hpm_q[i];
            hit = 1'b1;
          end
        end
      end
      v = hit ? (a[7] ? sel[63:32] : sel[31:0]) : 32'h0;
    end
  endfunction

  always_comb begin
    lookup(read_address, rd_value, rd_hit);
    lookup(write_back_address, wb_old, wb_hit);
  end

  // Cxx shadows are read-only; only mapped non-Cxx addresses accept writes.
  assign wb_req = |write_back;
  assign wb_ok  = wb_hit && (write_back_address[11:8] != 4'hC);
  assign wb_do  = wb_req && wb_ok;

  always_comb begin
    wb_new = wb_old;
    case (write_back)
      2'b11:   wb_new = write_back_data;
      2'b10:   wb_new = wb_old | write_back_data;
      2'b01:   wb_new = wb_old & ~write_back_data;
      default: wb_new = wb_old;
    endcase
  end

  logic wr_cycle_lo, wr_cycle_hi, wr_instret_lo, wr_instret_hi, wr_inhibit;
  assign wr_cycle_lo   = wb_do && (write_back_address == 12'hB00);
  assign wr_cycle_hi   = wb_do && (write_back_address == 12'hB80);
  assign wr_instret_lo = wb_do && (write_back_address == 12'hB02);
  assign wr_instret_hi = wb_do && (write_back_address == 12'hB82);
  assign wr_inhibit    = wb_do && (write_back_address == 12'h320);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
    end else if (wr_cycle_lo) begin
      cycle_q <= {cycle_q[63:32], wb_new};
    end else if (wr_cycle_hi) begin
      cycle_q <= {wb_new, cycle_q[31:0]};
    end else if (!inhibit_q[0]) begin
      cycle_q <= cycle_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_q <= '0;
    end else if (TIME_EN && time_tick) begin
      time_q <= time_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (wr_instret_lo) begin
      instret_q <= {instret_q[63:32], wb_new};
    end else if (wr_instret_hi) begin
      instret_q <= {wb_new, instret_q[31:0]};
    end else if (increment_instret && !inhibit_q[2]) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  generate
    if (NUM_HPM > 0) begin : g_hpm
      for (genvar g = 0; g < NUM_HPM; g++) begin : g_cnt
        localparam logic [11:0] LO_ADDR = 12'hB03 + 12'(g);
        localparam logic [11:0] HI_ADDR = 12'hB83 + 12'(g);
        logic wr_lo, wr_hi;
        assign wr_lo = wb_do && (write_back_address == LO_ADDR);
        assign wr_hi = wb_do && (write_back_address == HI_ADDR);
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            hpm_q[g] <= '0;
          end else if (wr_lo) begin
            hpm_q[g] <= {hpm_q[g][63:32], wb_new};
          end else if (wr_hi) begin
            hpm_q[g] <= {wb_new, hpm_q[g][31:0]};
          end else if (hpm_event[g] && !inhibit_q[3+g]) begin
            hpm_q[g] <= hpm_q[g] + 64'd1;
          end
        end
      end
    end else begin : g_no_hpm
      assign hpm_q[0] = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inhibit_q <= '0;
    end else if (wr_inhibit) begin
      inhibit_q <= wb_new & INHIBIT_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data   <= '0;
      read_valid  <= 1'b0;
      read_error  <= 1'b0;
      write_error <= 1'b0;
    end else begin
      read_valid  <= read;
      read_error  <= read && !rd_hit;
      write_error <= wb_req && !wb_ok;
      if (read) begin
        read_data <= rd_value;
      end
    end
  end

endmodule

`default_nettype wire
